frame_write_packer: RTL and testbench
=====================================

Name: frame_write_packer

Overview:
- Sits directly downstream of the tile renderer, which emits one 16-bit RGB565 pixel per valid cycle (at most every 2nd cycle) tagged with h_count/v_count, plus a last flag.
- Packs 8 horizontally consecutive pixels into one 128-bit DRAM word and computes its word address in one of two 1280x720 framebuffers.
- Buffers words in a FIFO toward the DRAM write interface (valid/ready).
- Flips the write framebuffer when a frame completes and reports the finished frame to the display reader.

Parameters:
- FIFO_DEPTH, 16, number of 128-bit words buffered (power of 2).
- H_RES, 1280, pixels per line (multiple of 8).
- V_RES, 720, lines per frame.
- FRAME_WORDS, 115200, words per framebuffer (H_RES*V_RES/8).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- px_h_count  in  11  pixel column
- px_v_count  in  10  pixel row
- px_valid  in  1  pixel strobe
- px_last  in  1  pixel is the last of its frame
- px_data  in  16  pixel colour
- wr_addr  out  18  word address = frame_base + v*(H_RES/8) + h[10:3]
- wr_data  out  128  packed pixels; lane n in bits [16n+15:16n]
- wr_last  out  1  word holds the frame's last pixel
- wr_valid  out  1  word available
- wr_ready  in  1  DRAM side accepts the word
- write_frame  out  1  framebuffer currently being written
- frame_done  out  1  one-cycle pulse when the final word of a frame is accepted
- display_frame  out  1  most recently completed framebuffer
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full
- misalign  out  1  sticky: a pixel arrived out of lane order

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - Outputs: wr_valid=0, write_frame=0, display_frame=1, frame_done=0, overflow=0, misalign=0, wr_last=0.
  - Internal: FIFO empty, expected lane=0, word register cleared.
- Packing: lane = px_h_count[2:0]. On px_valid, px_data is stored in lane `lane` of the word register.
- Ordering check:
  - If lane != expected lane, set misalign. Restart the word with this pixel in its own lane; earlier partial lanes are undefined (not cleared).
  - Expected lane becomes lane+1 mod 8.
- Word completion: on the cycle a lane-7 pixel is sampled, the word is pushed into the FIFO on the next clock edge.
  - Address: write_frame*FRAME_WORDS + v*160 + h[10:3].
  - wr_last equals px_last of the lane-7 pixel.
  - px_last on a non-lane-7 pixel is ignored and sets misalign.
- FIFO: first-word-fall-through.
  - wr_valid rises the cycle after the push, so input-to-wr_valid latency is 2 cycles when the FIFO is empty.
  - Pop when wr_valid && wr_ready.
  - Push and pop in the same cycle with a full FIFO is allowed (count unchanged).
  - Push while full with no pop: the word is dropped, overflow is set, and the FIFO contents are unchanged.
  - wr_addr, wr_data and wr_last are held stable while wr_valid && !wr_ready.
- Frame flip: applies when a word with wr_last=1 is popped.
  - frame_done pulses high for that single cycle.
  - display_frame <= write_frame on that same edge.
  - write_frame toggles on that same edge.
  - Words already queued keep the frame base computed at push time. Pixels of the next frame arriving before the flip use the old base; the upstream renderer's done/idle gap guarantees the FIFO drains first, and this block does not protect against it.
- A dropped wr_last word (overflow) does not flip the frame.
- Width rules:
  - v*160 is computed as (v<<7)+(v<<5), 17 bits.
  - Address sums are 18 bits, no wrap expected (max 230399).
- Sticky flags clear only on reset.
- Reset mid-frame: the FIFO and partial word are discarded and write_frame returns to 0. No wr_valid is asserted until new full words form.

Test Plan:
1. 8 pixels h=0..7, v=0, data 0x1111..0x8888 every 2nd cycle, wr_ready=1 -> one word, wr_data=0x8888_7777_..._1111, wr_addr=0, wr_valid 2 cycles after the 8th pixel.
2. Pixel run h=1272..1279, v=719, last on h=1279 -> wr_addr=115199, wr_last=1; on the pop, frame_done pulses once, write_frame=1, display_frame=0. The next frame's first word (h=0, v=0) gets wr_addr=115200.
3. wr_ready=0 while 17 words complete -> 16 stored, overflow=1, first wr_data unchanged. Then wr_ready=1 -> exactly 16 pops in order.
4. Pixels h=0,1,2, then h=8..15 -> misalign=1, one word emitted with wr_addr=1 and lanes holding h=8..15 data.
5. rst_n low mid-row with 5 FIFO words pending -> wr_valid=0 immediately; after release, write_frame=0 and overflow=0.
6. wr_valid held with wr_ready toggling every cycle while pixels stream -> no word lost or duplicated, wr_* stable while stalled.

Source files
------------

// File: rtl/frame_write_packer_if.sv
// frame_write_packer_if
//   DRAM write-side bus of the frame write packer: one 128-bit word per
//   wr_valid && wr_ready handshake.
//   wr_addr  : 18-bit word address inside the two framebuffers
//   wr_data  : 8 packed RGB565 pixels, lane n in bits [16n+15:16n]
//   wr_last  : word carries the last pixel of a frame
//   wr_valid : word available (driven by the packer)
//   wr_ready : DRAM side accepts the word (driven by the DRAM side)
//   Modports: master = packer side, slave = DRAM writer side.
interface frame_write_packer_if;
  logic [17:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_last;
  logic         wr_valid;
  logic         wr_ready;

  modport master (output wr_addr, output wr_data, output wr_last,
                  output wr_valid, input wr_ready);
  modport slave  (input wr_addr, input wr_data, input wr_last,
                  input wr_valid, output wr_ready);
endinterface

// File: rtl/frame_write_packer.sv
// frame_write_packer
//   Packs 8 horizontally consecutive RGB565 pixels from the tile renderer into
//   128-bit DRAM words, computes each word's address in one of two
//   framebuffers, queues the words in a first-word-fall-through FIFO and flips
//   the write framebuffer when the frame's last word is accepted.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   px_h_count/v_count  : pixel column / row
//   px_valid, px_last   : pixel strobe, last pixel of the frame
//   px_data             : RGB565 colour
//   wr                  : DRAM write bus (frame_write_packer_if.master)
//   write_frame         : framebuffer currently being written
//   frame_done          : pulse on the cycle the frame's last word is popped
//   display_frame       : most recently completed framebuffer
//   overflow            : sticky, a completed word was dropped (FIFO full)
//   misalign            : sticky, a pixel arrived out of lane order
module frame_write_packer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int H_RES       = 1280,
  parameter int V_RES       = 720,
  parameter int FRAME_WORDS = H_RES * V_RES / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [10:0]                 px_h_count,
  input  logic [9:0]                  px_v_count,
  input  logic                        px_valid,
  input  logic                        px_last,
  input  logic [15:0]                 px_data,
  frame_write_packer_if.master        wr,
  output logic                        write_frame,
  output logic                        frame_done,
  output logic                        display_frame,
  output logic                        overflow,
  output logic                        misalign
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 128 + 18 + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [16:0]      WORDS_PER_LINE = 17'(H_RES / 8);

  // Packing state
  logic [7:0][15:0] word_q, word_d;
  logic [2:0]       exp_lane_q, exp_lane_d;

  // Completed word waiting for its FIFO push on the following edge
  logic             pend_valid_q, pend_valid_d;
  logic [127:0]     pend_data_q, pend_data_d;
  logic [17:0]      pend_addr_q, pend_addr_d;
  logic             pend_last_q, pend_last_d;

  // FIFO storage and pointers
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  // Frame / status state
  logic write_frame_q, write_frame_d;
  logic display_frame_q, display_frame_d;
  logic overflow_q, overflow_d;
  logic misalign_q, misalign_d;

  logic [2:0]         lane;
  logic [16:0]        v_offset;
  logic [17:0]        frame_base;
  logic [17:0]        px_addr;
  logic [ENTRY_W-1:0] head;
  logic               fifo_valid;
  logic               pop;
  logic               push_ok;

  assign lane       = px_h_count[2:0];
  assign fifo_valid = (count_q != '0);
  assign head       = mem[rd_ptr_q];
  assign pop        = fifo_valid && wr.wr_ready;

  assign wr.wr_valid = fifo_valid;
  assign wr.wr_data  = head[127:0];
  assign wr.wr_addr  = head[145:128];
  // FIFO storage is not reset, so wr_last is qualified to read 0 when empty
  assign wr.wr_last  = fifo_valid && head[146];

  assign frame_done    = pop && head[146];
  assign write_frame   = write_frame_q;
  assign display_frame = display_frame_q;
  assign overflow      = overflow_q;
  assign misalign      = misalign_q;

  // Word address of the current pixel; v*160 is a constant multiply that
  // reduces to (v<<7)+(v<<5) for 1280-pixel lines.
  always_comb begin
    v_offset   = 17'(px_v_count) * WORDS_PER_LINE;
    frame_base = write_frame_q ? 18'(FRAME_WORDS) : 18'd0;
    px_addr    = frame_base + 18'(v_offset) + 18'(px_h_count[10:3]);
  end

  // Lane packing, order checking and word completion
  always_comb begin
    word_d       = word_q;
    exp_lane_d   = exp_lane_q;
    misalign_d   = misalign_q;
    pend_valid_d = 1'b0;
    pend_data_d  = pend_data_q;
    pend_addr_d  = pend_addr_q;
    pend_last_d  = pend_last_q;
    if (px_valid) begin
      // An out-of-order pixel simply lands in its own lane: the word restarts
      // from here and stale lanes are left as they are.
      word_d[lane] = px_data;
      exp_lane_d   = lane + 3'd1;
      if ((lane != exp_lane_q) || (px_last && (lane != 3'd7))) begin
        misalign_d = 1'b1;
      end
      if (lane == 3'd7) begin
        pend_valid_d = 1'b1;
        pend_data_d  = word_d;
        pend_addr_d  = px_addr;
        pend_last_d  = px_last;
      end
    end
  end

  // FIFO push/pop bookkeeping and frame flip
  always_comb begin
    push_ok         = pend_valid_q && ((count_q != FULL_CNT) || pop);
    overflow_d      = overflow_q | (pend_valid_q & ~push_ok);
    rd_ptr_d        = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    wr_ptr_d        = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    count_d         = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_ONE;
    end
    write_frame_d   = write_frame_q;
    display_frame_d = display_frame_q;
    if (frame_done) begin
      display_frame_d = write_frame_q;
      write_frame_d   = ~write_frame_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q          <= '0;
      exp_lane_q      <= 3'd0;
      pend_valid_q    <= 1'b0;
      pend_data_q     <= '0;
      pend_addr_q     <= '0;
      pend_last_q     <= 1'b0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      write_frame_q   <= 1'b0;
      display_frame_q <= 1'b1;
      overflow_q      <= 1'b0;
      misalign_q      <= 1'b0;
    end else begin
      word_q          <= word_d;
      exp_lane_q      <= exp_lane_d;
      pend_valid_q    <= pend_valid_d;
      pend_data_q     <= pend_data_d;
      pend_addr_q     <= pend_addr_d;
      pend_last_q     <= pend_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      write_frame_q   <= write_frame_d;
      display_frame_q <= display_frame_d;
      overflow_q      <= overflow_d;
      misalign_q      <= misalign_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= {pend_last_q, pend_addr_q, pend_data_q};
    end
  end

endmodule

// File: tb/tb_frame_write_packer.sv
// tb_frame_write_packer
//   Randomised, scoreboard-checked bench for frame_write_packer. A reference
//   model follows the block's rules at word level (lanes, FIFO as a queue,
//   frame flip on the popped last word) and pushes expected words; a monitor
//   compares every word the DUT hands over plus the status outputs.
module tb_frame_write_packer;

  localparam int DEPTH = 16;
  localparam int FW    = 115200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] px_h_count = '0;
  logic [9:0]  px_v_count = '0;
  logic        px_valid = 1'b0;
  logic        px_last = 1'b0;
  logic [15:0] px_data = '0;
  logic        write_frame, frame_done, display_frame, overflow, misalign;

  frame_write_packer_if wr_if();

  frame_write_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .px_h_count    (px_h_count),
    .px_v_count    (px_v_count),
    .px_valid      (px_valid),
    .px_last       (px_last),
    .px_data       (px_data),
    .wr            (wr_if),
    .write_frame   (write_frame),
    .frame_done    (frame_done),
    .display_frame (display_frame),
    .overflow      (overflow),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0]  addr;
    logic [127:0] data;
    logic         last;
  } word_t;

  word_t mdl_q[$];
  word_t sb_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    pop_count = 0;
  int    fd_count = 0;
  int    ready_mode = 0;

  logic [15:0] mdl_lanes [8];
  int    mdl_exp_lane;
  bit    mdl_wf, mdl_disp, mdl_ovf, mdl_mis;
  bit    mdl_pend;
  word_t mdl_pend_w;

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mdl_q.delete();
    sb_q.delete();
    mdl_exp_lane = 0;
    mdl_wf = 0;
    mdl_disp = 1;
    mdl_ovf = 0;
    mdl_mis = 0;
    mdl_pend = 0;
    for (int i = 0; i < 8; i++) mdl_lanes[i] = '0;
  endtask

  // One clock edge of the reference model
  task automatic modelStep();
    bit    new_pend;
    word_t new_w;
    bit    do_pop;
    int    lane;
    new_pend = 0;
    new_w = '{addr: '0, data: '0, last: 0};
    if (px_valid) begin
      lane = int'(px_h_count) % 8;
      if (lane != mdl_exp_lane || (px_last && lane != 7)) mdl_mis = 1;
      mdl_lanes[lane] = px_data;
      mdl_exp_lane = (lane + 1) % 8;
      if (lane == 7) begin
        new_pend = 1;
        for (int i = 0; i < 8; i++) new_w.data[16*i +: 16] = mdl_lanes[i];
        new_w.addr = 18'((mdl_wf ? FW : 0) + int'(px_v_count) * 160 + int'(px_h_count) / 8);
        new_w.last = px_last;
      end
    end
    do_pop = (mdl_q.size() != 0) && wr_if.wr_ready;
    if (do_pop) begin
      word_t h;
      h = mdl_q.pop_front();
      if (h.last) begin
        mdl_disp = mdl_wf;
        mdl_wf = ~mdl_wf;
      end
    end
    if (mdl_pend) begin
      if (mdl_q.size() >= DEPTH) begin
        mdl_ovf = 1;
      end else begin
        mdl_q.push_back(mdl_pend_w);
        sb_q.push_back(mdl_pend_w);
      end
    end
    mdl_pend = new_pend;
    mdl_pend_w = new_w;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge
  bit           prev_stall = 0;
  logic [17:0]  prev_addr;
  logic [127:0] prev_data;
  logic         prev_last;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        bit    hs;
        bit    exp_fd;
        word_t h;
        checkOutput("wr_valid", wr_if.wr_valid, mdl_q.size() != 0);
        checkOutput("write_frame", write_frame, mdl_wf);
        checkOutput("display_frame", display_frame, mdl_disp);
        checkOutput("overflow", overflow, mdl_ovf);
        checkOutput("misalign", misalign, mdl_mis);
        if (prev_stall) begin
          checkOutput("stall_valid", wr_if.wr_valid, 1);
          checkOutput("stall_addr", wr_if.wr_addr, prev_addr);
          checkOutput("stall_data", wr_if.wr_data, prev_data);
          checkOutput("stall_last", wr_if.wr_last, prev_last);
        end
        hs = wr_if.wr_valid && wr_if.wr_ready;
        exp_fd = 0;
        if (hs) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_word", 1, 0);
          end else begin
            h = sb_q.pop_front();
            exp_fd = h.last;
            checkOutput("wr_addr", wr_if.wr_addr, h.addr);
            checkOutput("wr_data", wr_if.wr_data, h.data);
            checkOutput("wr_last", wr_if.wr_last, h.last);
          end
          pop_count++;
        end
        checkOutput("frame_done", frame_done, exp_fd);
        if (frame_done) fd_count++;
        prev_stall = wr_if.wr_valid && !wr_if.wr_ready;
        prev_addr = wr_if.wr_addr;
        prev_data = wr_if.wr_data;
        prev_last = wr_if.wr_last;
      end
    end
  end

  // wr_ready driver: mode 0 holds the value set by the tests
  initial begin
    wr_if.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) wr_if.wr_ready = ~wr_if.wr_ready;
      else if (ready_mode == 2) wr_if.wr_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // One pixel for one cycle, followed by 1+gap idle cycles
  task automatic applyStimulus(input int h, input int v, input logic [15:0] d,
                               input bit last, input int gap);
    px_h_count = 11'(h);
    px_v_count = 10'(v);
    px_data = d;
    px_last = last;
    px_valid = 1'b1;
    @(posedge clk);
    #1;
    px_valid = 1'b0;
    px_last = 1'b0;
    repeat (1 + gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendWord(input int hw, input int v, input bit last, input int maxgap);
    for (int l = 0; l < 8; l++) begin
      applyStimulus(hw * 8 + l, v, 16'($urandom), last && (l == 7),
                    $urandom_range(0, maxgap));
    end
  endtask

  task automatic waitDrain(input int budget);
    int c;
    c = 0;
    repeat (4) @(posedge clk);
    while (sb_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    checkOutput("drain_words_left", sb_q.size(), 0);
  endtask

  initial begin
    logic [127:0] first_data;
    logic [127:0] exp_word;
    logic [15:0]  d;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_wr_valid", wr_if.wr_valid, 0);
    checkOutput("reset_write_frame", write_frame, 0);
    checkOutput("reset_display_frame", display_frame, 1);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_misalign", misalign, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_wr_last", wr_if.wr_last, 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: first word, patterned data, 2-cycle latency
    $display("[TB] test 1: single word");
    wr_if.wr_ready = 1'b1;
    for (int l = 0; l < 8; l++) begin
      d = 16'(16'h1111 * (l + 1));
      applyStimulus(l, 0, d, 0, 0);
    end
    checkOutput("t1_valid", wr_if.wr_valid, 1);
    checkOutput("t1_data", wr_if.wr_data,
                128'h8888_7777_6666_5555_4444_3333_2222_1111);
    checkOutput("t1_addr", wr_if.wr_addr, 0);
    waitDrain(100);

    // 2: last word of a frame, then first word of the next frame
    $display("[TB] test 2: frame flip");
    fd_count = 0;
    sendWord(159, 719, 1, 0);
    waitDrain(100);
    checkOutput("t2_frame_done_pulses", fd_count, 1);
    checkOutput("t2_write_frame", write_frame, 1);
    checkOutput("t2_display_frame", display_frame, 0);
    sendWord(0, 0, 0, 0);
    checkOutput("t2_next_addr", wr_if.wr_addr, 115200);
    waitDrain(100);

    // 3: 17 words with the DRAM side stalled
    $display("[TB] test 3: overflow");
    wr_if.wr_ready = 1'b0;
    sendWord(0, 5, 0, 0);
    first_data = wr_if.wr_data;
    for (int i = 1; i < 17; i++) sendWord(i, 5, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t3_overflow", overflow, 1);
    checkOutput("t3_first_data", wr_if.wr_data, first_data);
    pop_count = 0;
    wr_if.wr_ready = 1'b1;
    waitDrain(200);
    checkOutput("t3_pops", pop_count, 16);

    // 4: out-of-order pixels restart the word
    $display("[TB] test 4: misalign");
    for (int h = 0; h < 3; h++) applyStimulus(h, 0, 16'($urandom), 0, 0);
    exp_word = '0;
    for (int h = 8; h < 16; h++) begin
      d = 16'($urandom);
      exp_word[16*(h-8) +: 16] = d;
      applyStimulus(h, 0, d, 0, 0);
    end
    checkOutput("t4_misalign", misalign, 1);
    checkOutput("t4_valid", wr_if.wr_valid, 1);
    checkOutput("t4_addr", wr_if.wr_addr, 18'((mdl_wf ? FW : 0) + 1));
    checkOutput("t4_data", wr_if.wr_data, exp_word);
    waitDrain(100);

    // 5: reset mid-row with words pending
    $display("[TB] test 5: reset mid-frame");
    wr_if.wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) sendWord(i, 10, 0, 0);
    for (int h = 0; h < 3; h++) applyStimulus(h, 11, 16'($urandom), 0, 0);
    checkOutput("t5_valid_before", wr_if.wr_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_valid_in_reset", wr_if.wr_valid, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_write_frame", write_frame, 0);
    checkOutput("t5_overflow", overflow, 0);
    checkOutput("t5_misalign", misalign, 0);
    checkOutput("t5_valid_after", wr_if.wr_valid, 0);
    wr_if.wr_ready = 1'b1;
    sendWord(3, 3, 0, 0);
    waitDrain(100);

    // 6: wr_ready toggling every cycle while streaming
    $display("[TB] test 6: toggling ready");
    ready_mode = 1;
    for (int i = 0; i < 10; i++) sendWord(i + 20, 100 + i, 0, 0);
    ready_mode = 0;
    wr_if.wr_ready = 1'b1;
    waitDrain(200);

    // 7: random positions, gaps, ready and occasional frame ends
    $display("[TB] test 7: random traffic");
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      sendWord($urandom_range(0, 159), $urandom_range(0, 719),
               ($urandom_range(0, 7) == 0), 3);
    end
    ready_mode = 0;
    wr_if.wr_ready = 1'b1;
    waitDrain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

endmodule
